// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin sharing of one cache request port between masters m0 and m1.
// Optional ARB_TIMEOUT_EN aborts a request the cache leaves unacknowledged for TIMEOUT_CYC cycles.
module cache_port_arbiter #(
   parameter int unsigned AW          = 16,
   parameter int unsigned DW          = 32,
   parameter int unsigned BW          = 4,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_wr,
   input  logic          m0_rd,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic [BW-1:0] m0_bval,
   output logic          m0_ack,
   output logic          m0_err,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_busy,
   input  logic          m1_wr,
   input  logic          m1_rd,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic [BW-1:0] m1_bval,
   output logic          m1_ack,
   output logic          m1_err,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_busy,
   output logic          c_wr,
   output logic          c_rd,
   output logic [AW-1:0] c_addr,
   output logic [DW-1:0] c_wdata,
   output logic [BW-1:0] c_bval,
   input  logic          c_ack,
   input  logic [DW-1:0] c_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t          state_q, state_d;
   logic            gnt_q, gnt_d, rr_q, rr_d;
   logic [1:0]      stb, wreq, cap, clr;
   logic [1:0]      valid_q, valid_d, op_q, ack_q, ack_d;
   logic [AW-1:0]   in_addr  [2];
   logic [DW-1:0]   in_wdata [2];
   logic [BW-1:0]   in_bval  [2];
   logic [AW-1:0]   addr_q   [2];
   logic [DW-1:0]   wdata_q  [2];
   logic [BW-1:0]   bval_q   [2];
   logic [DW-1:0]   rdata_q  [2];
   logic [DW-1:0]   rdata_d  [2];
   logic            c_wr_q, c_wr_d, c_rd_q, c_rd_d;
   logic [AW-1:0]   c_addr_q, c_addr_d;
   logic [DW-1:0]   c_wdata_q, c_wdata_d;
   logic [BW-1:0]   c_bval_q, c_bval_d;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      err_q, err_d;
`endif

   assign stb      = {m1_wr | m1_rd, m0_wr | m0_rd};
   assign wreq     = {m1_wr, m0_wr};
   assign in_addr[0]  = m0_addr;
   assign in_addr[1]  = m1_addr;
   assign in_wdata[0] = m0_wdata;
   assign in_wdata[1] = m1_wdata;
   assign in_bval[0]  = m0_bval;
   assign in_bval[1]  = m1_bval;

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      rr_d      = rr_q;
      c_wr_d    = 1'b0;
      c_rd_d    = 1'b0;
      c_addr_d  = c_addr_q;
      c_wdata_d = c_wdata_q;
      c_bval_d  = c_bval_q;
      ack_d     = '0;
      clr       = '0;
      for (int unsigned i = 0; i < 2; i++) rdata_d[i] = rdata_q[i];
`ifdef ARB_TIMEOUT_EN
      err_d     = '0;
      cnt_d     = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (|valid_q) begin
               // both pending: the master not last served wins
               gnt_d     = (valid_q == 2'b11) ? ~rr_q : valid_q[1];
               rr_d      = gnt_d;
               c_addr_d  = addr_q[gnt_d];
               c_wdata_d = wdata_q[gnt_d];
               c_bval_d  = bval_q[gnt_d];
               c_wr_d    = op_q[gnt_d];
               c_rd_d    = ~op_q[gnt_d];
               state_d   = ISSUE;
`ifdef ARB_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end
         end
         ISSUE, WAIT: begin
            state_d = WAIT;
            if (c_ack) begin
               ack_d[gnt_q] = 1'b1;
               clr[gnt_q]   = 1'b1;
               if (!op_q[gnt_q]) rdata_d[gnt_q] = c_rdata;
               state_d      = IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
               ack_d[gnt_q] = 1'b1;
               err_d[gnt_q] = 1'b1;
               clr[gnt_q]   = 1'b1;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      // a strobe arriving on the completion edge refills the slot being freed
      for (int unsigned i = 0; i < 2; i++) begin
         cap[i]     = stb[i] & (~valid_q[i] | clr[i]);
         valid_d[i] = cap[i] | (valid_q[i] & ~clr[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         gnt_q     <= 1'b0;
         rr_q      <= 1'b1;
         valid_q   <= '0;
         op_q      <= '0;
         ack_q     <= '0;
         c_wr_q    <= 1'b0;
         c_rd_q    <= 1'b0;
         c_addr_q  <= '0;
         c_wdata_q <= '0;
         c_bval_q  <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            addr_q[i]  <= '0;
            wdata_q[i] <= '0;
            bval_q[i]  <= '0;
            rdata_q[i] <= '0;
         end
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= '0;
         err_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         rr_q      <= rr_d;
         valid_q   <= valid_d;
         ack_q     <= ack_d;
         c_wr_q    <= c_wr_d;
         c_rd_q    <= c_rd_d;
         c_addr_q  <= c_addr_d;
         c_wdata_q <= c_wdata_d;
         c_bval_q  <= c_bval_d;
         for (int unsigned i = 0; i < 2; i++) begin
            rdata_q[i] <= rdata_d[i];
            if (cap[i]) begin
               addr_q[i]  <= in_addr[i];
               wdata_q[i] <= in_wdata[i];
               bval_q[i]  <= in_bval[i];
               op_q[i]    <= wreq[i];
            end
         end
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         err_q     <= err_d;
`endif
      end
   end

   assign c_wr     = c_wr_q;
   assign c_rd     = c_rd_q;
   assign c_addr   = c_addr_q;
   assign c_wdata  = c_wdata_q;
   assign c_bval   = c_bval_q;
   assign m0_ack   = ack_q[0];
   assign m1_ack   = ack_q[1];
   assign m0_rdata = rdata_q[0];
   assign m1_rdata = rdata_q[1];
   assign m0_busy  = valid_q[0];
   assign m1_busy  = valid_q[1];
`ifdef ARB_TIMEOUT_EN
   assign m0_err   = err_q[0];
   assign m1_err   = err_q[1];
`else
   assign m0_err   = 1'b0;
   assign m1_err   = 1'b0;
`endif

endmodule
